weight_bank_arb: RTL and testbench
==================================

# weight_bank_arb

Round-robin arbiter that shares the single weight-bank command port among `NUM_REQ` weight controllers. Each requester issues bursts framed by sos/eos; once a burst's sos beat is granted, the arbiter locks to that requester until its eos beat is accepted. The arbiter sits between the per-PE weight controllers and the weight bank, and registers every command it forwards.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `ADDR_W`, 8: bank address width.
- `ID_W`, `$clog2(NUM_REQ)`: source-ID width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_sos`  in  NUM_REQ  beat is the first of a burst.
- `req_eos`  in  NUM_REQ  beat is the last of a burst; may coincide with sos.
- `req_change`  in  NUM_REQ  layer-change marker, forwarded unchanged.
- `req_addr`  in  NUM_REQ×ADDR_W  per-requester address.
- `req_ready`  out  NUM_REQ  beat accepted when valid && ready.
- `bank_valid`  out  1  registered command valid.
- `bank_sos`, `bank_eos`, `bank_change`  out  1 each  registered framing bits.
- `bank_addr`  out  ADDR_W  registered address.
- `bank_src`  out  ID_W  requester index of the current beat.
- `bank_ready`  in  1  bank accepts the beat when bank_valid && bank_ready.
- `busy`  out  1  a burst is locked (state LOCKED).
- `err_nosos`  out  1  sticky flag: a beat without sos was presented while IDLE.

## Operation
- Two states. IDLE: no owner. LOCKED: `owner` holds the bank.
- `out_free` = !bank_valid || bank_ready.
- In IDLE, a requester is a candidate when it has valid && sos. The winner is the first candidate at or after `rr_ptr`, searching in increasing index order with wrap-around.
- If `out_free` in IDLE, the winner gets req_ready=1 in the same cycle. Its beat is loaded into the output register.
- If the accepted beat has eos=0: go to LOCKED, owner=winner.
- If the accepted beat has eos=1 (single-beat burst): stay IDLE and set rr_ptr = winner+1 mod NUM_REQ.
- In LOCKED, only the owner may get req_ready, and only when `out_free`. Every other requester sees req_ready=0.
- When the owner's accepted beat has eos=1: go to IDLE and set rr_ptr = owner+1 mod NUM_REQ. The next burst can be granted in the following cycle (one-cycle turnaround).
- A sos on the owner while LOCKED is forwarded unchanged and does not reset the lock.
- In IDLE, a valid beat without sos is never granted. It sets `err_nosos` (sticky until reset).
- `bank_src` records the index of the accepted requester. The output register holds its value while bank_valid && !bank_ready.
- When `out_free` and no beat is accepted, bank_valid clears to 0.

## Timing
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0, owner=0.
  - All bank_* outputs=0, busy=0, err_nosos=0.
  - req_ready=0 for the duration of reset.
- Latency: a beat accepted in cycle n appears on bank_* in cycle n+1.
- Throughput: one beat per cycle while bank_ready=1.
- req_ready is combinational from req_valid, req_sos, state, bank_valid and bank_ready. No other path is combinational.
- Reset mid-burst drops the lock and the output beat. There is no replay.
- Simultaneous eos acceptance and a new sos from another requester: the new sos is not granted that cycle. It is granted next cycle using the updated rr_ptr.

## Structure
- Shared package: a `wb_cmd_t` struct {sos, eos, change, addr} and a `wb_arb_state_t` enum {IDLE, LOCKED}. These sit alongside the existing `Weight_Cntl2bank` typedef.
- One sub-module, `rr_pick`: a combinational one-hot round-robin selector with inputs (mask, ptr) and outputs (grant, index).

## Test plan
- Single requester: req0 sends a 3-beat burst (sos, mid, eos) with addr 5, 6, 7 and bank_ready=1 → bank_valid high for cycles 1–3, bank_src=0, busy=1 for 2 cycles, rr_ptr=1 afterwards.
- Contention: req0 and req2 raise sos in the same cycle with rr_ptr=0 → req0 is served first. req2's sos is held (ready=0) until the cycle after req0's eos, then granted; next rr_ptr=3.
- Back-pressure: bank_ready=0 for 4 cycles mid-burst → bank_addr stays stable, owner req_ready=0, and there is no beat loss or duplication.
- Single-beat bursts: all 4 requesters issue sos&eos continuously → grants rotate 0, 1, 2, 3, 0, with one beat per cycle.
- Protocol error: req1 shows valid with sos=0 while IDLE → never granted, err_nosos=1 and stays 1.
- Async reset mid-burst: reset_n low during LOCKED → busy, bank_valid and err_nosos go to 0 immediately. After release, req3's sos is granted with rr_ptr=0 logic.

Source files
------------

// File: rtl/weight_bank_arb_pkg.sv
// Shared types for the weight-bank command arbiter and its weight-controller clients.
package weight_bank_arb_pkg;

  localparam int unsigned WB_ADDR_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wb_arb_state_t;

  typedef struct packed {
    logic                 sos;
    logic                 eos;
    logic                 change;
    logic [WB_ADDR_W-1:0] addr;
  } wb_cmd_t;

  // Controller-to-bank beat as seen on a single controller port.
  typedef struct packed {
    logic    valid;
    wb_cmd_t cmd;
  } Weight_Cntl2bank;

endpackage

// File: rtl/weight_bank_arb_rr_pick.sv
// Combinational round-robin selector: first set bit of mask at or after ptr, with wrap.
module weight_bank_arb_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] index
);

  int unsigned     pos;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      idx = ID_W'(pos);
      if (!found && mask[idx]) begin
        grant[idx] = 1'b1;
        index      = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_bank_arb.sv
// Round-robin, burst-locking arbiter sharing the weight-bank command port among NUM_REQ controllers.
module weight_bank_arb
  import weight_bank_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_sos,
  input  logic [NUM_REQ-1:0]        req_eos,
  input  logic [NUM_REQ-1:0]        req_change,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bank_valid,
  output logic                      bank_sos,
  output logic                      bank_eos,
  output logic                      bank_change,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [ID_W-1:0]           bank_src,
  input  logic                      bank_ready,
  output logic                      busy,
  output logic                      err_nosos
);

  wb_arb_state_t       state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     src_q, sel;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  cand, pick_grant, ready_c;
  logic                out_free, accept;
  logic                valid_q;
  logic                err_q, err_d;
  wb_cmd_t             cmd_q, cmd_sel;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    if (i == ID_W'(NUM_REQ - 1)) return '0;
    return i + ID_W'(1);
  endfunction

  assign out_free = !valid_q || bank_ready;
  assign cand     = req_valid & req_sos;

  weight_bank_arb_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .mask  (cand),
    .ptr   (rr_q),
    .grant (pick_grant),
    .index (pick_idx)
  );

  // Grant decision and arbitration state transitions.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    err_d   = err_q;
    ready_c = '0;
    accept  = 1'b0;
    sel     = owner_q;
    case (state_q)
      IDLE: begin
        if (|(req_valid & ~req_sos)) err_d = 1'b1;
        if (out_free && |cand) begin
          ready_c = pick_grant;
          accept  = 1'b1;
          sel     = pick_idx;
          if (req_eos[pick_idx]) begin
            rr_d = next_idx(pick_idx);
          end else begin
            state_d = LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        // A repeated sos from the owner is just another beat; only eos releases the lock.
        if (out_free && req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          accept           = 1'b1;
          if (req_eos[owner_q]) begin
            state_d = IDLE;
            rr_d    = next_idx(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_sel        = '0;
    cmd_sel.sos    = req_sos[sel];
    cmd_sel.eos    = req_eos[sel];
    cmd_sel.change = req_change[sel];
    cmd_sel.addr   = WB_ADDR_W'(addr_arr[sel]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      if (accept) begin
        valid_q <= 1'b1;
        cmd_q   <= cmd_sel;
        src_q   <= sel;
      end else if (out_free) begin
        valid_q <= 1'b0;
      end
    end
  end

  // req_ready is the only combinational output; it is forced low while reset is held.
  assign req_ready   = reset_n ? ready_c : '0;
  assign bank_valid  = valid_q;
  assign bank_sos    = cmd_q.sos;
  assign bank_eos    = cmd_q.eos;
  assign bank_change = cmd_q.change;
  assign bank_addr   = ADDR_W'(cmd_q.addr);
  assign bank_src    = src_q;
  assign busy        = (state_q == LOCKED);
  assign err_nosos   = err_q;

endmodule

// File: tb/tb_weight_bank_arb.sv
// Bench for weight_bank_arb: directed vector table, reset corner sequence, random run vs. model.
module tb_weight_bank_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_sos, req_eos, req_change, req_ready;
  logic [31:0] req_addr;
  logic        bank_valid, bank_sos, bank_eos, bank_change, bank_ready, busy, err_nosos;
  logic [7:0]  bank_addr;
  logic [1:0]  bank_src;

  always #5 clk = ~clk;

  weight_bank_arb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_sos     (req_sos),
    .req_eos     (req_eos),
    .req_change  (req_change),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .bank_valid  (bank_valid),
    .bank_sos    (bank_sos),
    .bank_eos    (bank_eos),
    .bank_change (bank_change),
    .bank_addr   (bank_addr),
    .bank_src    (bank_src),
    .bank_ready  (bank_ready),
    .busy        (busy),
    .err_nosos   (err_nosos)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v, s, e;
    logic [31:0] a;
    logic        br;
    logic [3:0]  rdy;
    logic        bv;
    logic [7:0]  ba;
    logic [1:0]  bs;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                              input logic [31:0] a, input logic br, input logic [3:0] rdy,
                              input logic bv, input logic [7:0] ba, input logic [1:0] bs,
                              input logic bsy, input logic err);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.a = a; t.br = br; t.rdy = rdy;
    t.bv = bv; t.ba = ba; t.bs = bs; t.bsy = bsy; t.err = err;
    return t;
  endfunction

  // Reference model: who owns the bank, where the search starts, and the registered beat.
  int         m_owner, m_rr, m_src;
  logic       m_bv, m_sos, m_eos, m_chg, m_err;
  logic [7:0] m_addr;

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    int idx;
    r = '0;
    if (m_bv && !bank_ready) return r;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_rr + k) % 4;
        if (req_valid[2'(idx)] && req_sos[2'(idx)]) begin
          r[2'(idx)] = 1'b1;
          return r;
        end
      end
    end else if (req_valid[2'(m_owner)]) begin
      r[2'(m_owner)] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step(input logic [3:0] r);
    int w;
    w = 0;
    if (m_owner < 0 && (req_valid & ~req_sos) != 4'b0) m_err = 1'b1;
    if (r != 4'b0) begin
      for (int k = 0; k < 4; k++) if (r[2'(k)]) w = k;
      m_bv   = 1'b1;
      m_sos  = req_sos[2'(w)];
      m_eos  = req_eos[2'(w)];
      m_chg  = req_change[2'(w)];
      m_addr = 8'(req_addr >> (w * 8));
      m_src  = w;
      if (req_eos[2'(w)]) begin
        m_owner = -1;
        m_rr    = (w + 1) % 4;
      end else begin
        m_owner = w;
      end
    end else if (!m_bv || bank_ready) begin
      m_bv = 1'b0;
    end
  endtask

  logic [3:0] g_vld, g_sos, g_eos, g_chg;
  int         g_left [4];
  logic [7:0] g_addr [4];

  initial begin
    vec_t       t;
    logic [3:0] er;

    // Directed vectors; bank_* expectations reflect beats accepted in the previous cycle.
    tv.push_back(mk(4'h1, 4'h1, 4'h0, 32'h0000_0005, 1, 4'h1, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h1, 4'h0, 4'h0, 32'h0000_0006, 1, 4'h1, 1, 8'h05, 0, 1, 0));
    tv.push_back(mk(4'h1, 4'h0, 4'h1, 32'h0000_0007, 1, 4'h1, 1, 8'h06, 0, 1, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 8'h07, 0, 0, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h8, 4'h8, 4'h8, 32'h0900_0000, 1, 4'h8, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h5, 4'h5, 4'h0, 32'h0014_000a, 1, 4'h1, 1, 8'h09, 3, 0, 0));
    tv.push_back(mk(4'h5, 4'h4, 4'h1, 32'h0014_000b, 1, 4'h1, 1, 8'h0a, 0, 1, 0));
    tv.push_back(mk(4'h4, 4'h4, 4'h0, 32'h0014_0000, 1, 4'h4, 1, 8'h0b, 0, 0, 0));
    tv.push_back(mk(4'h4, 4'h0, 4'h4, 32'h0015_0000, 1, 4'h4, 1, 8'h14, 2, 1, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 8'h15, 2, 0, 0));
    tv.push_back(mk(4'h9, 4'h9, 4'h9, 32'h2100_001e, 1, 4'h8, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h1, 4'h1, 4'h1, 32'h0000_001e, 1, 4'h1, 1, 8'h21, 3, 0, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 8'h1e, 0, 0, 0));
    tv.push_back(mk(4'h2, 4'h2, 4'h0, 32'h0000_2800, 1, 4'h2, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h2, 4'h0, 4'h0, 32'h0000_2900, 1, 4'h2, 1, 8'h28, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(4'ha, 4'h8, 4'h8, 32'h5000_2a00, 0, 4'h0, 1, 8'h29, 1, 1, 0));
    tv.push_back(mk(4'ha, 4'h8, 4'ha, 32'h5000_2a00, 1, 4'h2, 1, 8'h29, 1, 1, 0));
    tv.push_back(mk(4'h8, 4'h8, 4'h8, 32'h5000_0000, 1, 4'h8, 1, 8'h2a, 1, 0, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 8'h50, 3, 0, 0));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h2, 4'h0, 4'h0, 32'h0000_3c00, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(4'h2, 4'h0, 4'h0, 32'h0000_3c00, 1, 4'h0, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(4'hf, 4'hf, 4'hf, 32'h0403_0201, 1, 4'h1, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(4'hf, 4'hf, 4'hf, 32'h0403_0201, 1, 4'h2, 1, 8'h01, 0, 0, 1));
    tv.push_back(mk(4'hf, 4'hf, 4'hf, 32'h0403_0201, 1, 4'h4, 1, 8'h02, 1, 0, 1));
    tv.push_back(mk(4'hf, 4'hf, 4'hf, 32'h0403_0201, 1, 4'h8, 1, 8'h03, 2, 0, 1));
    tv.push_back(mk(4'hf, 4'hf, 4'hf, 32'h0403_0201, 1, 4'h1, 1, 8'h04, 3, 0, 1));
    tv.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 8'h01, 0, 0, 1));

    // Reset with requests pending: nothing may be granted.
    reset_n    = 1'b0;
    req_valid  = 4'hf;
    req_sos    = 4'hf;
    req_eos    = 4'h0;
    req_change = 4'h0;
    req_addr   = 32'hffff_ffff;
    bank_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(bank_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err_nosos), 32'h0);
    chk("rst_addr", 32'(bank_addr), 32'h0);
    chk("rst_src", 32'(bank_src), 32'h0);
    chk("rst_flags", 32'({bank_sos, bank_eos, bank_change}), 32'h0);
    req_valid = 4'h0;
    req_sos   = 4'h0;
    req_addr  = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      t          = tv[i];
      req_valid  = t.v;
      req_sos    = t.s;
      req_eos    = t.e;
      req_addr   = t.a;
      bank_ready = t.br;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(t.rdy));
      chk($sformatf("vec%0d_valid", i), 32'(bank_valid), 32'(t.bv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(t.bsy));
      chk($sformatf("vec%0d_err", i), 32'(err_nosos), 32'(t.err));
      if (t.bv) begin
        chk($sformatf("vec%0d_addr", i), 32'(bank_addr), 32'(t.ba));
        chk($sformatf("vec%0d_src", i), 32'(bank_src), 32'(t.bs));
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a locked burst.
    req_valid = 4'h1; req_sos = 4'h1; req_eos = 4'h0; req_addr = 32'h70;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_sos = 4'h0; req_addr = 32'h71;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_valid", 32'(bank_valid), 32'h0);
    chk("arst_err", 32'(err_nosos), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'h8; req_sos = 4'h8; req_eos = 4'h8; req_addr = 32'h3300_0000;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bank_valid), 32'h1);
    chk("post_rst_src", 32'(bank_src), 32'h3);
    chk("post_rst_addr", 32'(bank_addr), 32'h33);

    // Random bursts with gaps and back-pressure against the reference model.
    reset_n = 1'b0;
    req_valid = 4'h0; req_sos = 4'h0; req_eos = 4'h0; req_change = 4'h0;
    m_owner = -1; m_rr = 0; m_src = 0;
    m_bv = 1'b0; m_sos = 1'b0; m_eos = 1'b0; m_chg = 1'b0; m_err = 1'b0; m_addr = '0;
    g_vld = '0; g_sos = '0; g_eos = '0; g_chg = '0;
    for (int i = 0; i < 4; i++) begin
      g_left[i] = 0;
      g_addr[i] = '0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!g_vld[i] && ($urandom % 3) == 0) begin
          g_left[i] = int'($urandom_range(1, 4));
          g_vld[i]  = 1'b1;
          g_sos[i]  = 1'b1;
          g_eos[i]  = (g_left[i] == 1);
          g_addr[i] = 8'($urandom);
          g_chg[i]  = 1'($urandom);
        end
        req_valid[i]  = g_vld[i] && (($urandom % 5) != 0);
        req_sos[i]    = g_sos[i];
        req_eos[i]    = g_eos[i];
        req_change[i] = g_chg[i];
      end
      req_addr   = {g_addr[3], g_addr[2], g_addr[1], g_addr[0]};
      bank_ready = ($urandom % 4) != 0;
      @(negedge clk);
      er = m_ready();
      chk("rand_ready", 32'(req_ready), 32'(er));
      chk("rand_valid", 32'(bank_valid), 32'(m_bv));
      chk("rand_busy", 32'(busy), 32'(m_owner >= 0));
      chk("rand_err", 32'(err_nosos), 32'(m_err));
      if (m_bv) begin
        chk("rand_addr", 32'(bank_addr), 32'(m_addr));
        chk("rand_src", 32'(bank_src), 32'(m_src));
        chk("rand_frame", 32'({bank_sos, bank_eos, bank_change}), 32'({m_sos, m_eos, m_chg}));
      end
      model_step(er);
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          g_left[i] = g_left[i] - 1;
          if (g_left[i] == 0) begin
            g_vld[i] = 1'b0;
            g_sos[i] = 1'b0;
            g_eos[i] = 1'b0;
          end else begin
            g_sos[i]  = 1'b0;
            g_eos[i]  = (g_left[i] == 1);
            g_addr[i] = 8'($urandom);
            g_chg[i]  = 1'($urandom);
          end
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
